// File: rtl/packet_assembler_if.sv
// Purpose: flit ingress and reassembled-packet egress handshakes of the packet assembler.
// Latency: none, this is a wire bundle.
// Backpressure: flit_ready throttles the flit source; pkt_ready throttles packet egress.
interface packet_assembler_if #(
  parameter int NODE_COUNT      = 8,
  parameter int PACKET_ID_WIDTH = 5
);
  localparam int N  = $clog2(NODE_COUNT);
  localparam int P  = PACKET_ID_WIDTH;
  localparam int FW = 1 + 2 * N + 17 + P + 2;

  logic [FW-1:0] flit_in;
  logic          flit_valid;
  logic          flit_ready;
  logic [67:0]   pkt_out;
  logic [N-1:0]  src_out;
  logic [P-1:0]  id_out;
  logic          pkt_valid;
  logic          pkt_ready;

  // Flit source / packet sink side
  modport master (
    output flit_in, flit_valid, pkt_ready,
    input  flit_ready, pkt_out, src_out, id_out, pkt_valid
  );

  // Assembler side
  modport slave (
    input  flit_in, flit_valid, pkt_ready,
    output flit_ready, pkt_out, src_out, id_out, pkt_valid
  );
endinterface

// File: rtl/packet_assembler.sv
// Purpose: small generic FIFO with registered occupancy count and zeroed storage on reset.
// Latency: a push is visible at the head one edge later when the FIFO was empty.
// Backpressure: caller must not push when full or pop when empty; count is exported for that.
module pa_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Explicit wrap keeps the pointers legal even for non power-of-two depths.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage, pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];
endmodule

// Purpose: reassembles 4-flit packets keyed by {src, id} across SLOTS concurrent contexts.
// Latency: final flit accepted at edge k -> packet at FIFO head in cycle k+1 if the FIFO was empty.
// Backpressure: flit_ready drops while the output FIFO is full; pkt_ready pops the FIFO head.
module packet_assembler #(
  parameter int NODE_ID         = 0,
  parameter int NODE_COUNT      = 8,
  parameter int PACKET_ID_WIDTH = 5,
  parameter int SLOTS           = 4,
  parameter int OUT_DEPTH       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  packet_assembler_if.slave io,
  output logic              drop_pulse,
  output logic              dup_pulse
);
  localparam int N  = $clog2(NODE_COUNT);
  localparam int P  = PACKET_ID_WIDTH;
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int CW = $clog2(OUT_DEPTH) + 1;
  localparam int QW = 68 + N + P;

  typedef struct packed {
    logic         vld;
    logic [N-1:0] dest;
    logic [16:0]  payload;
    logic [P-1:0] id;
    logic [N-1:0] src;
    logic [1:0]   idx;
  } flit_t;

  typedef struct packed {
    logic         busy;
    logic [N-1:0] src;
    logic [P-1:0] id;
    logic [3:0]   mask;
    logic [67:0]  data;
  } slot_t;

  flit_t         flit;
  slot_t         slots [SLOTS];
  logic          hit;
  logic [SW-1:0] hit_idx;
  logic          have_free;
  logic [SW-1:0] free_idx;
  logic [SW-1:0] tgt;
  logic          accept;
  logic          apply;
  logic          complete;
  logic          drop_evt;
  logic          dup_evt;
  logic [3:0]    cur_mask;
  logic [3:0]    new_mask;
  logic [67:0]   new_data;
  logic          fifo_pop;
  logic [QW-1:0] fifo_head;
  logic [CW-1:0] fifo_cnt;
  logic          unused_bits;

  assign flit = io.flit_in;

  // The destination field and node index are carried for information only.
  assign unused_bits = ^{flit.dest, NODE_ID[0]};

  // Key lookup: matching open context, and the lowest-index free context.
  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    have_free = 1'b0;
    free_idx  = '0;
    for (int s = SLOTS - 1; s >= 0; s--) begin
      if (slots[s].busy && slots[s].src == flit.src && slots[s].id == flit.id) begin
        hit     = 1'b1;
        hit_idx = SW'(s);
      end
      if (!slots[s].busy) begin
        have_free = 1'b1;
        free_idx  = SW'(s);
      end
    end
  end

  assign accept   = ce && io.flit_valid && flit.vld && io.flit_ready;
  assign tgt      = hit ? hit_idx : free_idx;
  assign apply    = accept && (hit || have_free);
  assign drop_evt = accept && !hit && !have_free;
  // A fresh allocation starts from an empty mask, so it can never flag a duplicate.
  assign cur_mask = hit ? slots[hit_idx].mask : 4'b0000;
  assign dup_evt  = apply && cur_mask[flit.idx];
  assign new_mask = cur_mask | (4'b0001 << flit.idx);
  assign complete = apply && (new_mask == 4'b1111);

  // Drop the payload into its quarter; idx 0 lands in the most significant quarter.
  always_comb begin
    new_data = slots[tgt].data;
    case (flit.idx)
      2'd0:    new_data[67:51] = flit.payload;
      2'd1:    new_data[50:34] = flit.payload;
      2'd2:    new_data[33:17] = flit.payload;
      default: new_data[16:0]  = flit.payload;
    endcase
  end

  // Context update: complete packets leave for the FIFO and free their slot on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SLOTS; s++) slots[s] <= '0;
    end else if (apply) begin
      if (complete) begin
        slots[tgt].busy <= 1'b0;
        slots[tgt].mask <= 4'b0000;
      end else begin
        slots[tgt].busy <= 1'b1;
        slots[tgt].src  <= flit.src;
        slots[tgt].id   <= flit.id;
        slots[tgt].mask <= new_mask;
        slots[tgt].data <= new_data;
      end
    end
  end

  // Event pulses follow their event by one edge and clear on the next, so each lasts one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_pulse <= 1'b0;
      dup_pulse  <= 1'b0;
    end else begin
      drop_pulse <= drop_evt;
      dup_pulse  <= dup_evt;
    end
  end

  assign fifo_pop = io.pkt_valid && io.pkt_ready && ce;

  pa_fifo #(
    .WIDTH (QW),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (complete),
    .push_dat ({new_data, flit.src, flit.id}),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .count    (fifo_cnt)
  );

  // Ready looks only at the registered count; a pop in the same cycle does not free a place early.
  assign io.flit_ready = ce && (fifo_cnt < CW'(OUT_DEPTH));
  assign io.pkt_valid  = (fifo_cnt != '0);
  assign {io.pkt_out, io.src_out, io.id_out} = fifo_head;
endmodule

// File: tb/tb_packet_assembler.sv
// Purpose: directed self-checking bench for packet_assembler.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: exercises FIFO-full stall via pkt_ready low.
module tb_packet_assembler;
  logic clk = 1'b0;
  logic rst_n;
  logic ce;
  logic drop_pulse;
  logic dup_pulse;
  int   n_chk  = 0;
  int   n_fail = 0;

  packet_assembler_if #(.NODE_COUNT(8), .PACKET_ID_WIDTH(5)) pif ();

  packet_assembler #(
    .NODE_ID         (0),
    .NODE_COUNT      (8),
    .PACKET_ID_WIDTH (5),
    .SLOTS           (4),
    .OUT_DEPTH       (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .io         (pif.slave),
    .drop_pulse (drop_pulse),
    .dup_pulse  (dup_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [67:0] mk(input logic [16:0] p0, input logic [16:0] p1,
                                     input logic [16:0] p2, input logic [16:0] p3);
    return {p0, p1, p2, p3};
  endfunction

  // Present one flit for a single rising edge; called and returns on a falling edge.
  task automatic send(input logic v, input int src, input int id, input int idx, input logic [16:0] pay);
    pif.flit_in    = {v, 3'd0, pay, 5'(id), 3'(src), 2'(idx)};
    pif.flit_valid = 1'b1;
    @(negedge clk);
    pif.flit_valid = 1'b0;
    pif.flit_in    = '0;
  endtask

  // Check the FIFO head then pop it.
  task automatic expect_pkt(input string tag, input logic [67:0] pkt, input int src, input int id);
    check({tag, ".vld"}, 68'(pif.pkt_valid), 68'd1);
    check({tag, ".pkt"}, pif.pkt_out, pkt);
    check({tag, ".src"}, 68'(pif.src_out), 68'(src));
    check({tag, ".id"},  68'(pif.id_out),  68'(id));
    pif.pkt_ready = 1'b1;
    @(negedge clk);
    pif.pkt_ready = 1'b0;
  endtask

  function automatic logic [16:0] pay_of(input int key, input int idx);
    return 17'(32'h04000 + key * 16 + idx);
  endfunction

  int ord [4] = '{3, 1, 0, 2};

  initial begin
    ce             = 1'b1;
    rst_n          = 1'b0;
    pif.flit_in    = '0;
    pif.flit_valid = 1'b0;
    pif.pkt_ready  = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst.flit_ready", 68'(pif.flit_ready), 68'd1);
    check("rst.pkt_valid",  68'(pif.pkt_valid),  68'd0);
    check("rst.pkt_out",    pif.pkt_out,         68'd0);
    check("rst.src_out",    68'(pif.src_out),    68'd0);
    check("rst.id_out",     68'(pif.id_out),     68'd0);
    check("rst.drop",       68'(drop_pulse),     68'd0);
    check("rst.dup",        68'(dup_pulse),      68'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst.flit_ready", 68'(pif.flit_ready), 68'd1);

    // Clock enable low deasserts ready
    ce = 1'b0;
    #1;
    check("ce_low.flit_ready", 68'(pif.flit_ready), 68'd0);
    ce = 1'b1;
    @(negedge clk);

    // Flits with vld=0 are ignored
    for (int i = 0; i < 4; i++) send(1'b0, 2, 5, i, 17'h1FFFF);
    check("novld.pkt_valid", 68'(pif.pkt_valid), 68'd0);
    check("novld.drop",      68'(drop_pulse),    68'd0);

    // In-order single packet
    send(1'b1, 2, 5, 0, 17'h1A5A5);
    check("t1.nodup", 68'(dup_pulse), 68'd0);
    send(1'b1, 2, 5, 1, 17'h0F0F0);
    send(1'b1, 2, 5, 2, 17'h13579);
    check("t1.early", 68'(pif.pkt_valid), 68'd0);
    send(1'b1, 2, 5, 3, 17'h02468);
    expect_pkt("t1", mk(17'h1A5A5, 17'h0F0F0, 17'h13579, 17'h02468), 2, 5);
    check("t1.empty", 68'(pif.pkt_valid), 68'd0);

    // Interleaved packets, out-of-order idx
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 1, 3, ord[i], 17'(32'h0AA00 + ord[i]));
      send(1'b1, 4, 3, ord[i], 17'(32'h15500 + ord[i]));
    end
    expect_pkt("t2a", mk(17'h0AA00, 17'h0AA01, 17'h0AA02, 17'h0AA03), 1, 3);
    expect_pkt("t2b", mk(17'h15500, 17'h15501, 17'h15502, 17'h15503), 4, 3);
    check("t2.empty", 68'(pif.pkt_valid), 68'd0);

    // All contexts open, new key dropped
    for (int k = 0; k < 4; k++) send(1'b1, k, 1, 0, pay_of(k, 0));
    send(1'b1, 5, 7, 0, 17'h1FFFF);
    check("t3.drop", 68'(drop_pulse), 68'd1);
    @(negedge clk);
    check("t3.drop_once", 68'(drop_pulse), 68'd0);
    for (int k = 0; k < 4; k++)
      for (int i = 1; i < 4; i++) send(1'b1, k, 1, i, pay_of(k, i));
    check("t3.full", 68'(pif.flit_ready), 68'd0);
    for (int k = 0; k < 4; k++)
      expect_pkt($sformatf("t3.p%0d", k), mk(pay_of(k, 0), pay_of(k, 1), pay_of(k, 2), pay_of(k, 3)), k, 1);
    for (int i = 1; i < 4; i++) send(1'b1, 5, 7, i, pay_of(57, i));
    check("t3.no_ghost", 68'(pif.pkt_valid), 68'd0);
    send(1'b1, 5, 7, 0, pay_of(57, 0));
    expect_pkt("t3.late", mk(pay_of(57, 0), pay_of(57, 1), pay_of(57, 2), pay_of(57, 3)), 5, 7);

    // Output backpressure
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++) send(1'b1, 6, k, i, pay_of(60 + k, i));
    check("t4.full", 68'(pif.flit_ready), 68'd0);
    pif.flit_in    = {1'b1, 3'd0, 17'h1ABCD, 5'd9, 3'd7, 2'd0};
    pif.flit_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("t4.stall%0d.rdy", c), 68'(pif.flit_ready), 68'd0);
      check($sformatf("t4.stall%0d.head", c), pif.pkt_out,
            mk(pay_of(60, 0), pay_of(60, 1), pay_of(60, 2), pay_of(60, 3)));
    end
    pif.flit_valid = 1'b0;
    pif.flit_in    = '0;
    for (int k = 0; k < 4; k++)
      expect_pkt($sformatf("t4.p%0d", k), mk(pay_of(60 + k, 0), pay_of(60 + k, 1),
                 pay_of(60 + k, 2), pay_of(60 + k, 3)), 6, k);
    check("t4.ready_back", 68'(pif.flit_ready), 68'd1);
    for (int i = 0; i < 4; i++) send(1'b1, 7, 9, i, pay_of(79, i));
    expect_pkt("t4.p5", mk(pay_of(79, 0), pay_of(79, 1), pay_of(79, 2), pay_of(79, 3)), 7, 9);
    check("t4.empty", 68'(pif.pkt_valid), 68'd0);

    // Duplicate idx
    send(1'b1, 3, 2, 0, 17'h00011);
    send(1'b1, 3, 2, 1, 17'h0AAAA);
    check("t5.first", 68'(dup_pulse), 68'd0);
    send(1'b1, 3, 2, 1, 17'h15555);
    check("t5.dup", 68'(dup_pulse), 68'd1);
    @(negedge clk);
    check("t5.dup_once", 68'(dup_pulse), 68'd0);
    send(1'b1, 3, 2, 2, 17'h00033);
    check("t5.not_done", 68'(pif.pkt_valid), 68'd0);
    send(1'b1, 3, 2, 3, 17'h00044);
    expect_pkt("t5", mk(17'h00011, 17'h15555, 17'h00033, 17'h00044), 3, 2);

    // Reset mid-packet
    send(1'b1, 5, 4, 0, 17'h00101);
    send(1'b1, 5, 4, 1, 17'h00102);
    rst_n = 1'b0;
    #1;
    check("t6.rst.pkt_valid",  68'(pif.pkt_valid),  68'd0);
    check("t6.rst.pkt_out",    pif.pkt_out,         68'd0);
    check("t6.rst.src_out",    68'(pif.src_out),    68'd0);
    check("t6.rst.id_out",     68'(pif.id_out),     68'd0);
    check("t6.rst.flit_ready", 68'(pif.flit_ready), 68'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(1'b1, 5, 4, 0, 17'h00201);
    check("t6.nodup", 68'(dup_pulse), 68'd0);
    send(1'b1, 5, 4, 1, 17'h00202);
    send(1'b1, 5, 4, 2, 17'h00203);
    check("t6.not_done", 68'(pif.pkt_valid), 68'd0);
    send(1'b1, 5, 4, 3, 17'h00204);
    expect_pkt("t6", mk(17'h00201, 17'h00202, 17'h00203, 17'h00204), 5, 4);
    check("t6.only_one", 68'(pif.pkt_valid), 68'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/packet_assembler.md
PACKET_ASSEMBLER -- requirements
Module: packet_assembler

Interface
REQ-001 Parameter NODE_ID, default 0: local node index; informational only, not checked against the flit destination.
REQ-002 Parameter NODE_COUNT, default 8: node count; N = $clog2(NODE_COUNT).
REQ-003 Parameter PACKET_ID_WIDTH, default 5: packet id width P.
REQ-004 Parameter SLOTS, default 4: concurrent reassembly contexts.
REQ-005 Parameter OUT_DEPTH, default 4: output FIFO depth (power of 2).
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 ce  input  1  clock enable; when low, no state changes.
REQ-009 flit_in  input  FW=1+2N+17+P+2  flit {vld[1], dest[N], payload[17], id[P], src[N], idx[2]}, MSB first.
REQ-010 flit_valid  input  1  flit_in carries a flit this cycle.
REQ-011 flit_ready  output  1  flit accepted when flit_valid && flit_ready.
REQ-012 pkt_out  output  68  reassembled packet.
REQ-013 src_out  output  N  originating node of pkt_out.
REQ-014 id_out  output  P  packet id of pkt_out.
REQ-015 pkt_valid  output  1  pkt_out/src_out/id_out valid.
REQ-016 pkt_ready  input  1  consumer accepts packet when pkt_valid && pkt_ready.
REQ-017 drop_pulse  output  1  one-cycle pulse: flit dropped, no free slot.
REQ-018 dup_pulse  output  1  one-cycle pulse: duplicate idx received for an open context.

Function
REQ-019 A flit is accepted only when ce && flit_valid && flit_in.vld && flit_ready; flits with vld=0 are ignored with no pulse.
REQ-020 flit_ready = ce && (output FIFO count < OUT_DEPTH), combinational from registered count; no same-cycle pop bypass.
REQ-021 Context key = {src, id}; an accepted flit matching an open slot's key updates that slot.
REQ-022 No match: allocate lowest-index free slot, set its key, clear its 4-bit mask, then apply the flit in the same cycle.
REQ-023 No match and no free slot: flit discarded, drop_pulse=1 next cycle, no state change.
REQ-024 Payload placement by idx: 0->[67:51], 1->[50:34], 2->[33:17], 3->[16:0]; mask bit idx set.
REQ-025 Flits of one packet may arrive in any idx order and interleaved with other packets.
REQ-026 Duplicate idx (mask bit already set): payload overwritten, dup_pulse=1 next cycle, mask unchanged.
REQ-027 When the mask becomes 4'b1111, the packet, src and id are pushed into the output FIFO and the slot freed on the same edge.
REQ-028 Latency: final flit accepted at edge k -> pkt_valid=1 after edge k (visible in cycle k+1) if the FIFO was empty.
REQ-029 Output FIFO: first-in first-out; pop on pkt_valid && pkt_ready && ce; simultaneous push and pop keeps count; pointers wrap modulo OUT_DEPTH.
REQ-030 pkt_valid = (count > 0); pkt_out/src_out/id_out show the FIFO head and stay stable while pkt_valid && !pkt_ready.
REQ-031 Arithmetic: count width $clog2(OUT_DEPTH)+1; no overflow since push requires flit_ready.
REQ-032 drop_pulse and dup_pulse are registered, high for exactly one cycle per event.

Reset
REQ-033 rst_n low (at any time, including mid-packet): all slots free, masks 0, FIFO empty, pkt_valid=0, pkt_out=0, src_out=0, id_out=0, drop_pulse=0, dup_pulse=0; partial packets discarded.
REQ-034 flit_ready equals ce during and immediately after reset.

Verification
REQ-035 Flits idx0..3 src=2 id=5 payloads 17'h1A5A5,17'h0F0F0,17'h13579,17'h02468 in order -> one packet {those concatenated}, src_out=2, id_out=5, pkt_valid one cycle after the last flit.
REQ-036 Interleave src=1 id=3 and src=4 id=3 with idx order 3,1,0,2 -> two correct packets in completion order.
REQ-037 Open 4 partial contexts, then send a new-key flit -> drop_pulse once, the other 4 packets still complete correctly.
REQ-038 pkt_ready=0, complete 4 packets -> flit_ready=0, 5th packet's flits stalled; pkt_ready=1 -> FIFO drains in order and flit_ready returns.
REQ-039 Send idx1 twice for one key -> dup_pulse once, second payload appears in [50:34].
REQ-040 Assert rst_n low after 2 of 4 flits -> outputs 0; resend all 4 -> exactly one packet out.
